key_debounce: RTL and testbench

Debounces one mechanical key/switch input and drives a clean, glitch-free level into the rising-edge detector stage that follows it. The block synchronizes the raw pad input into `clk`. It then requires the pressed or released state to stay stable for `DEBOUNCE_CYCLES` consecutive cycles before changing its output. It sits between the board pin and the edge-detect stage; its `key_level` output connects directly to that stage's signal input.

---
 rtl/key_debounce_pkg.sv | 19 +
 rtl/sync_2ff.sv | 27 ++
 rtl/key_debounce.sv | 145 ++++++++++++++
 tb/tb_key_debounce.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_debounce_pkg.sv
// Shared types and helpers for the key debouncer: FSM state encoding and
// the counter-width calculation used to size the qualification counter.
package key_debounce_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } key_state_t;

  // Width able to hold every value up to max(a, b) - 1; never narrower than 1 bit.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for an asynchronous pad input; the reset value lets
// the chain come out of reset holding the pad's idle level.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/key_debounce.sv
// Key/switch debouncer: synchronizes the pad, then qualifies each press and
// release over DEBOUNCE_CYCLES stable cycles. Optional long-press pulse is
// enabled by defining KEY_LONG_PRESS_EN.
module key_debounce
  import key_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int ACTIVE_LOW      = 1,
  parameter int LONG_CYCLES     = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_in,
  output logic key_level,
  output logic busy,
  output logic long_press
);

  localparam int            CW           = cnt_width(DEBOUNCE_CYCLES, LONG_CYCLES);
  localparam logic [CW-1:0] DEB_LAST     = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic          PAD_RELEASED = (ACTIVE_LOW != 0);
`ifdef KEY_LONG_PRESS_EN
  localparam logic [CW-1:0] LONG_LAST    = CW'(LONG_CYCLES - 1);
`endif

  logic          key_sync;
  logic          samp;
  key_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          busy_q, busy_d;
`ifdef KEY_LONG_PRESS_EN
  logic          long_q, long_d;
  logic          long_done_q, long_done_d;
`endif

  sync_2ff #(
    .RESET_VAL(PAD_RELEASED)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (key_in),
    .q    (key_sync)
  );

  // Normalize so that 1 always means pressed.
  assign samp = key_sync ^ PAD_RELEASED;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      level_q     <= 1'b0;
      busy_q      <= 1'b0;
`ifdef KEY_LONG_PRESS_EN
      long_q      <= 1'b0;
      long_done_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      level_q     <= level_d;
      busy_q      <= busy_d;
`ifdef KEY_LONG_PRESS_EN
      long_q      <= long_d;
      long_done_q <= long_done_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
`ifdef KEY_LONG_PRESS_EN
    long_d      = 1'b0;
    long_done_d = long_done_q;
`endif
    case (state_q)
      IDLE: begin
        if (samp) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!samp) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d = PRESSED;
          level_d = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PRESSED: begin
        if (!samp) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
`ifdef KEY_LONG_PRESS_EN
          long_done_d = 1'b0;
`endif
        end
`ifdef KEY_LONG_PRESS_EN
        // Counter saturates at the terminal value; the done flag keeps it to one pulse.
        else if (cnt_q != LONG_LAST) begin
          cnt_d = cnt_q + 1'b1;
        end else if (!long_done_q) begin
          long_d      = 1'b1;
          long_done_d = 1'b1;
        end
`endif
      end
      RELEASE_WAIT: begin
        if (samp) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d = IDLE;
          level_d = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        level_d = 1'b0;
      end
    endcase
    busy_d = (state_d == PRESS_WAIT) || (state_d == RELEASE_WAIT);
  end

  assign key_level = level_q;
  assign busy      = busy_q;
`ifdef KEY_LONG_PRESS_EN
  assign long_press = long_q;
`else
  assign long_press = 1'b0;
`endif

endmodule

// File: tb/tb_key_debounce.sv
// Self-checking bench for key_debounce: directed scenarios plus random key
// activity, all checked against a run-length reference model.
module tb_key_debounce;

  localparam int DEB  = 4;
  localparam int LONG = 10;
`ifdef KEY_LONG_PRESS_EN
  localparam bit LONG_EN = 1'b1;
`else
  localparam bit LONG_EN = 1'b0;
`endif

  logic clk    = 1'b0;
  logic rst_n  = 1'b0;
  logic key_in = 1'b1;
  logic key_level;
  logic busy;
  logic long_press;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: pressed samples delayed two clocks, level flips after
  // DEB+1 consecutive samples disagreeing with it.
  bit m_d1, m_d2;
  bit m_level;
  int m_run;
  int m_hold;
  bit m_long;

  always #5 clk = ~clk;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEB),
    .ACTIVE_LOW     (1),
    .LONG_CYCLES    (LONG)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_in    (key_in),
    .key_level (key_level),
    .busy      (busy),
    .long_press(long_press)
  );

  function automatic void model_reset();
    m_d1    = 1'b0;
    m_d2    = 1'b0;
    m_level = 1'b0;
    m_run   = 0;
    m_hold  = 0;
    m_long  = 1'b0;
  endfunction

  // Advance one clock edge, update the model, return 1 time unit after the edge.
  task automatic tick();
    bit pressed_now;
    bit s;
    pressed_now = (key_in == 1'b0);
    @(posedge clk);
    if (rst_n) begin
      s      = m_d2;
      m_d2   = m_d1;
      m_d1   = pressed_now;
      m_long = 1'b0;
      if (s != m_level) begin
        m_hold = 0;
        m_run++;
        if (m_run == DEB + 1) begin
          m_level = s;
          m_run   = 0;
        end
      end else begin
        if (LONG_EN && m_level && m_run == 0 && m_hold < LONG) begin
          m_hold++;
          m_long = (m_hold == LONG);
        end
        m_run = 0;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    key_in = 1'b1;
    model_reset();
    #1;
    vectors++;
    if ({key_level, busy, long_press} !== 3'b000) begin
      miscompares++;
      $display("[TB] FAIL reset_values: got %b expected 000", {key_level, busy, long_press});
    end
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      vectors++;
      if ({key_level, busy, long_press} !== 3'b000) begin
        miscompares++;
        $display("[TB] FAIL post_reset_idle cycle %0d: got %b expected 000", i, {key_level, busy, long_press});
      end
    end
  endtask

  task automatic test_clean_press();
    int rises, rise_edge, busy_cnt, pulses, pulse_edge, fall_edge;
    bit prev;
    rises = 0; rise_edge = -1; busy_cnt = 0; pulses = 0; pulse_edge = -1; fall_edge = -1;
    key_in = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      prev = key_level;
      tick();
      vectors++;
      if ({key_level, busy, long_press} !== {m_level, m_run != 0, m_long}) begin
        miscompares++;
        $display("[TB] FAIL press_model cycle %0d: got %b expected %b", i,
                 {key_level, busy, long_press}, {m_level, m_run != 0, m_long});
      end
      if (!prev && key_level) begin rises++; rise_edge = i; end
      if (busy) busy_cnt++;
      if (long_press) begin pulses++; pulse_edge = i; end
    end
    vectors++;
    if (rise_edge !== DEB + 3) begin
      miscompares++;
      $display("[TB] FAIL press_latency: got edge %0d expected edge %0d", rise_edge, DEB + 3);
    end
    vectors++;
    if (rises !== 1) begin
      miscompares++;
      $display("[TB] FAIL press_single_rise: got %0d rises expected 1", rises);
    end
    vectors++;
    if (busy_cnt !== DEB) begin
      miscompares++;
      $display("[TB] FAIL press_busy_window: got %0d busy cycles expected %0d", busy_cnt, DEB);
    end
    vectors++;
    if (pulses !== (LONG_EN ? 1 : 0) || pulse_edge !== (LONG_EN ? DEB + 3 + LONG : -1)) begin
      miscompares++;
      $display("[TB] FAIL long_press_pulse: got %0d pulses at edge %0d expected %0d at edge %0d",
               pulses, pulse_edge, LONG_EN ? 1 : 0, LONG_EN ? DEB + 3 + LONG : -1);
    end
    key_in = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      prev = key_level;
      tick();
      vectors++;
      if ({key_level, busy, long_press} !== {m_level, m_run != 0, m_long}) begin
        miscompares++;
        $display("[TB] FAIL release_model cycle %0d: got %b expected %b", i,
                 {key_level, busy, long_press}, {m_level, m_run != 0, m_long});
      end
      if (prev && !key_level) fall_edge = i;
    end
    vectors++;
    if (fall_edge !== DEB + 3) begin
      miscompares++;
      $display("[TB] FAIL release_latency: got edge %0d expected edge %0d", fall_edge, DEB + 3);
    end
  endtask

  task automatic test_bounce();
    int changes, rise_edge;
    bit prev;
    changes = 0; rise_edge = -1;
    for (int i = 0; i < 20; i++) begin
      key_in = ((i / 2) % 2 == 0) ? 1'b0 : 1'b1;
      prev = key_level;
      tick();
      vectors++;
      if ({key_level, busy, long_press} !== {m_level, m_run != 0, m_long}) begin
        miscompares++;
        $display("[TB] FAIL bounce_model cycle %0d: got %b expected %b", i,
                 {key_level, busy, long_press}, {m_level, m_run != 0, m_long});
      end
      if (prev != key_level) changes++;
    end
    vectors++;
    if (changes !== 0) begin
      miscompares++;
      $display("[TB] FAIL bounce_no_toggle: got %0d level changes expected 0", changes);
    end
    key_in = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      prev = key_level;
      tick();
      vectors++;
      if ({key_level, busy, long_press} !== {m_level, m_run != 0, m_long}) begin
        miscompares++;
        $display("[TB] FAIL bounce_settle cycle %0d: got %b expected %b", i,
                 {key_level, busy, long_press}, {m_level, m_run != 0, m_long});
      end
      if (!prev && key_level) rise_edge = i;
    end
    vectors++;
    if (rise_edge !== DEB + 3) begin
      miscompares++;
      $display("[TB] FAIL bounce_latency: got edge %0d expected edge %0d", rise_edge, DEB + 3);
    end
  endtask

  task automatic test_release_bounce();
    int drops, fall_edge;
    bit prev;
    drops = 0; fall_edge = -1;
    for (int i = 0; i < 11; i++) begin
      key_in = (i < 3) ? 1'b1 : 1'b0;
      tick();
      vectors++;
      if ({key_level, busy, long_press} !== {m_level, m_run != 0, m_long}) begin
        miscompares++;
        $display("[TB] FAIL release_bounce_model cycle %0d: got %b expected %b", i,
                 {key_level, busy, long_press}, {m_level, m_run != 0, m_long});
      end
      if (!key_level) drops++;
    end
    vectors++;
    if (drops !== 0 || busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL release_bounce_hold: got %0d low cycles busy=%b expected 0 and 0", drops, busy);
    end
    key_in = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      prev = key_level;
      tick();
      vectors++;
      if ({key_level, busy, long_press} !== {m_level, m_run != 0, m_long}) begin
        miscompares++;
        $display("[TB] FAIL release_after_bounce cycle %0d: got %b expected %b", i,
                 {key_level, busy, long_press}, {m_level, m_run != 0, m_long});
      end
      if (prev && !key_level) fall_edge = i;
    end
    vectors++;
    if (fall_edge !== DEB + 3) begin
      miscompares++;
      $display("[TB] FAIL release_bounce_latency: got edge %0d expected edge %0d", fall_edge, DEB + 3);
    end
  endtask

  task automatic test_async_reset();
    int rise_edge;
    bit prev;
    rise_edge = -1;
    key_in = 1'b0;
    repeat (5) tick();
    vectors++;
    if ({key_level, busy} !== 2'b01) begin
      miscompares++;
      $display("[TB] FAIL mid_qualify_busy: got %b expected 01", {key_level, busy});
    end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    vectors++;
    if ({key_level, busy, long_press} !== 3'b000) begin
      miscompares++;
      $display("[TB] FAIL async_reset_values: got %b expected 000", {key_level, busy, long_press});
    end
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      prev = key_level;
      tick();
      vectors++;
      if ({key_level, busy, long_press} !== {m_level, m_run != 0, m_long}) begin
        miscompares++;
        $display("[TB] FAIL repress_model cycle %0d: got %b expected %b", i,
                 {key_level, busy, long_press}, {m_level, m_run != 0, m_long});
      end
      if (!prev && key_level) rise_edge = i;
    end
    vectors++;
    if (rise_edge !== DEB + 3) begin
      miscompares++;
      $display("[TB] FAIL repress_latency: got edge %0d expected edge %0d", rise_edge, DEB + 3);
    end
    key_in = 1'b1;
    repeat (12) tick();
  endtask

  task automatic test_random();
    int run_left;
    run_left = 0;
    for (int i = 0; i < 400; i++) begin
      if (run_left == 0) begin
        key_in   = 1'($urandom_range(0, 1));
        run_left = $urandom_range(1, 24);
      end
      run_left--;
      tick();
      vectors++;
      if ({key_level, busy, long_press} !== {m_level, m_run != 0, m_long}) begin
        miscompares++;
        $display("[TB] FAIL random_model cycle %0d: got %b expected %b", i,
                 {key_level, busy, long_press}, {m_level, m_run != 0, m_long});
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_release_bounce();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] timeout");
  end

endmodule
